// File: rtl/operand_stage.sv
// Operand fetch/decode stage for a small RV32I subset: register file, pending-result
// scoreboard, hazard stall and a one-deep registered operand bundle for the ALU stage.
module operand_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [1:0]  alu_sel,
    output logic [4:0]  rd,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        illegal_instr
);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    logic [31:0] rf_q [32];
    logic [31:0] pending_q, pending_d;
    logic        ex_valid_q, ex_valid_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [1:0]  alu_sel_q, alu_sel_d;
    logic [4:0]  rd_q, rd_d;
    logic        illegal_q, illegal_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_f, rs2_f, rd_f;
    logic        dec_legal, dec_is_r;
    logic [1:0]  dec_sel;
    logic [31:0] dec_imm;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] clr_vec, eff_pend;
    logic        hazard, accept;

    assign opcode = instr[6:0];
    assign rd_f   = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1_f  = instr[19:15];
    assign rs2_f  = instr[24:20];
    assign funct7 = instr[31:25];

    always_comb begin
        dec_legal = 1'b0;
        dec_is_r  = 1'b0;
        dec_sel   = 2'b00;
        dec_imm   = {{20{instr[31]}}, instr[31:20]};
        if (opcode == OPC_R) begin
            dec_is_r = 1'b1;
            case ({funct7, funct3})
                10'b0000000_000: begin dec_legal = 1'b1; dec_sel = 2'b00; end
                10'b0100000_000: begin dec_legal = 1'b1; dec_sel = 2'b01; end
                10'b0000000_110: begin dec_legal = 1'b1; dec_sel = 2'b10; end
                10'b0000000_111: begin dec_legal = 1'b1; dec_sel = 2'b11; end
                default:         dec_legal = 1'b0;
            endcase
        end else if (opcode == OPC_I) begin
            case (funct3)
                3'b000:  begin dec_legal = 1'b1; dec_sel = 2'b00; end
                3'b110:  begin dec_legal = 1'b1; dec_sel = 2'b10; end
                3'b111:  begin dec_legal = 1'b1; dec_sel = 2'b11; end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    // Same-cycle writeback is forwarded so a stalled consumer issues on the wb cycle.
    always_comb begin
        if (rs1_f == 5'd0)
            rs1_val = 32'd0;
        else if (wb_en && wb_rd == rs1_f)
            rs1_val = wb_data;
        else
            rs1_val = rf_q[rs1_f];
        if (rs2_f == 5'd0)
            rs2_val = 32'd0;
        else if (wb_en && wb_rd == rs2_f)
            rs2_val = wb_data;
        else
            rs2_val = rf_q[rs2_f];
    end

    assign clr_vec  = wb_en ? (32'd1 << wb_rd) : 32'd0;
    assign eff_pend = pending_q & ~clr_vec;

    assign hazard = dec_legal &&
                    (eff_pend[rs1_f] ||
                     (dec_is_r && eff_pend[rs2_f]) ||
                     ((rd_f != 5'd0) && eff_pend[rd_f]));

    assign instr_ready = !rst && (!ex_valid_q || ex_ready) && !hazard;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        pending_d  = pending_q & ~clr_vec;
        ex_valid_d = ex_valid_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        alu_sel_d  = alu_sel_q;
        rd_d       = rd_q;
        illegal_d  = accept && !dec_legal;
        if (accept && dec_legal) begin
            ex_valid_d = 1'b1;
            op1_d      = rs1_val;
            op2_d      = dec_is_r ? rs2_val : dec_imm;
            alu_sel_d  = dec_sel;
            rd_d       = rd_f;
            if (rd_f != 5'd0)
                pending_d[rd_f] = 1'b1;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                rf_q[i] <= 32'd0;
            pending_q  <= 32'd0;
            ex_valid_q <= 1'b0;
            op1_q      <= 32'd0;
            op2_q      <= 32'd0;
            alu_sel_q  <= 2'b00;
            rd_q       <= 5'd0;
            illegal_q  <= 1'b0;
        end else begin
            if (wb_en && wb_rd != 5'd0)
                rf_q[wb_rd] <= wb_data;
            pending_q  <= pending_d;
            ex_valid_q <= ex_valid_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            alu_sel_q  <= alu_sel_d;
            rd_q       <= rd_d;
            illegal_q  <= illegal_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign op1           = op1_q;
    assign op2           = op2_q;
    assign alu_sel       = alu_sel_q;
    assign rd            = rd_q;
    assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: a reference model checked every cycle on the
// falling edge, plus literal expectations for the key scenarios.
module tb_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] op1, op2;
    logic [1:0]  alu_sel;
    logic [4:0]  rd;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal_instr;

    int n_checks = 0;
    int n_fail   = 0;

    operand_stage dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .op1(op1), .op2(op2), .alu_sel(alu_sel), .rd(rd),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [2:0] f3,
                                          input logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [4:0] d);
        return {imm, s1, f3, d, 7'b0010011};
    endfunction

    // Reference model: architectural state and expected bundle.
    logic [31:0] m_rf [32];
    logic [31:0] m_pend;
    logic        m_valid, m_ill;
    logic [31:0] m_op1, m_op2;
    logic [1:0]  m_sel;
    logic [4:0]  m_rd;
    bit          started = 0;

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_en && wb_rd == r) return wb_data;
        return m_rf[r];
    endfunction

    function automatic bit m_busy(input logic [4:0] r);
        return m_pend[r] && !(wb_en && wb_rd == r);
    endfunction

    always @(negedge clk) begin
        bit          legal, is_r, exp_rdy, acc;
        logic [1:0]  sel;
        logic [6:0]  opc;
        logic [4:0]  s1, s2, d;
        logic [31:0] imm;
        opc = instr[6:0];  d = instr[11:7];  s1 = instr[19:15];  s2 = instr[24:20];
        imm = {{20{instr[31]}}, instr[31:20]};
        legal = 0; is_r = 0; sel = 2'b00;
        if (opc == 7'b0110011) begin
            is_r = 1;
            if (instr[31:25] == 7'b0000000 && instr[14:12] == 3'b000) begin legal = 1; sel = 2'b00; end
            if (instr[31:25] == 7'b0100000 && instr[14:12] == 3'b000) begin legal = 1; sel = 2'b01; end
            if (instr[31:25] == 7'b0000000 && instr[14:12] == 3'b110) begin legal = 1; sel = 2'b10; end
            if (instr[31:25] == 7'b0000000 && instr[14:12] == 3'b111) begin legal = 1; sel = 2'b11; end
        end else if (opc == 7'b0010011) begin
            if (instr[14:12] == 3'b000) begin legal = 1; sel = 2'b00; end
            if (instr[14:12] == 3'b110) begin legal = 1; sel = 2'b10; end
            if (instr[14:12] == 3'b111) begin legal = 1; sel = 2'b11; end
        end
        exp_rdy = !rst && (!m_valid || ex_ready) &&
                  !(legal && (m_busy(s1) || (is_r && m_busy(s2)) || (d != 0 && m_busy(d))));
        if (started) begin
            chk("m_ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
            chk("m_op1", op1, m_op1);
            chk("m_op2", op2, m_op2);
            chk("m_alu_sel", {30'd0, alu_sel}, {30'd0, m_sel});
            chk("m_rd", {27'd0, rd}, {27'd0, m_rd});
            chk("m_illegal", {31'd0, illegal_instr}, {31'd0, m_ill});
            chk("m_instr_ready", {31'd0, instr_ready}, {31'd0, exp_rdy});
        end
        if (rst) begin
            started = 1;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m_pend = 0; m_valid = 0; m_ill = 0;
            m_op1 = 0; m_op2 = 0; m_sel = 0; m_rd = 0;
        end else begin
            acc   = instr_valid && exp_rdy;
            m_ill = acc && !legal;
            if (acc && legal) begin
                m_valid = 1;
                m_op1   = m_read(s1);
                m_op2   = is_r ? m_read(s2) : imm;
                m_sel   = sel;
                m_rd    = d;
            end else if (ex_ready) begin
                m_valid = 0;
            end
            if (wb_en) m_pend[wb_rd] = 1'b0;
            if (acc && legal && d != 0) m_pend[d] = 1'b1;
            if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
        end
    end

    task automatic drive(input bit v, input logic [31:0] w, input bit er,
                         input bit we, input logic [4:0] wr, input logic [31:0] wd);
        instr_valid = v; instr = w; ex_ready = er;
        wb_en = we; wb_rd = wr; wb_data = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 32'd0, 0, 0, 5'd0, 32'd0);
        tick(); tick();
        drive(1, i_ins(12'h000, 5'd1, 3'b000, 5'd15), 1, 1, 5'd1, 32'd77);
        chk("ready_in_reset", {31'd0, instr_ready}, 32'd0);
        tick();
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_op1", op1, 32'd0);
        chk("rst_op2", op2, 32'd0);
        chk("rst_illegal", {31'd0, illegal_instr}, 32'd0);

        rst = 1'b0;
        drive(1, i_ins(12'h000, 5'd1, 3'b000, 5'd15), 1, 0, 5'd0, 32'd0);
        chk("ready_idle", {31'd0, instr_ready}, 32'd1);
        tick();
        chk("wb_ignored_in_reset", op1, 32'd0);
        chk("addi_rd15", {27'd0, rd}, 32'd15);

        drive(0, 32'd0, 1, 1, 5'd1, 32'd5);  tick();
        drive(0, 32'd0, 1, 1, 5'd2, 32'd3);  tick();

        drive(1, r_ins(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3), 1, 0, 5'd0, 32'd0);
        tick();
        chk("sub_valid", {31'd0, ex_valid}, 32'd1);
        chk("sub_op1", op1, 32'd5);
        chk("sub_op2", op2, 32'd3);
        chk("sub_sel", {30'd0, alu_sel}, 32'd1);
        chk("sub_rd", {27'd0, rd}, 32'd3);

        drive(1, i_ins(12'hFFF, 5'd0, 3'b000, 5'd4), 1, 0, 5'd0, 32'd0);
        tick();
        chk("addi_op1", op1, 32'd0);
        chk("addi_op2", op2, 32'hFFFF_FFFF);
        chk("addi_sel", {30'd0, alu_sel}, 32'd0);

        drive(1, r_ins(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd5), 1, 0, 5'd0, 32'd0);
        tick();
        drive(1, r_ins(7'b0000000, 5'd1, 5'd5, 3'b110, 5'd6), 1, 0, 5'd0, 32'd0);
        chk("raw_stall_ready", {31'd0, instr_ready}, 32'd0);
        tick();
        chk("raw_stall_drained", {31'd0, ex_valid}, 32'd0);
        drive(1, r_ins(7'b0000000, 5'd1, 5'd5, 3'b110, 5'd6), 1, 1, 5'd5, 32'hA5);
        chk("raw_wb_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        chk("or_op1_bypass", op1, 32'hA5);
        chk("or_op2", op2, 32'd5);
        chk("or_sel", {30'd0, alu_sel}, 32'd2);

        for (int k = 0; k < 3; k++) begin
            drive(1, r_ins(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd7), 0, 0, 5'd0, 32'd0);
            chk("bp_ready", {31'd0, instr_ready}, 32'd0);
            tick();
            chk("bp_hold_op1", op1, 32'hA5);
            chk("bp_hold_rd", {27'd0, rd}, 32'd6);
            chk("bp_hold_valid", {31'd0, ex_valid}, 32'd1);
        end
        drive(1, r_ins(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd7), 1, 0, 5'd0, 32'd0);
        chk("bp_release_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        chk("and_sel", {30'd0, alu_sel}, 32'd3);
        chk("and_rd", {27'd0, rd}, 32'd7);

        drive(1, {12'd0, 5'd1, 3'b010, 5'd8, 7'b0000011}, 1, 0, 5'd0, 32'd0);
        chk("load_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        chk("load_illegal", {31'd0, illegal_instr}, 32'd1);
        chk("load_no_valid", {31'd0, ex_valid}, 32'd0);
        drive(0, 32'd0, 1, 0, 5'd0, 32'd0);
        tick();
        chk("illegal_one_pulse", {31'd0, illegal_instr}, 32'd0);

        drive(1, i_ins(12'h0F0, 5'd8, 3'b110, 5'd9), 1, 0, 5'd0, 32'd0);
        chk("load_no_pending", {31'd0, instr_ready}, 32'd1);
        tick();
        chk("ori_op2", op2, 32'h0000_00F0);

        drive(1, r_ins(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0), 1, 0, 5'd0, 32'd0);
        tick();
        chk("rd0_valid", {31'd0, ex_valid}, 32'd1);
        chk("rd0_rd", {27'd0, rd}, 32'd0);
        drive(1, i_ins(12'h000, 5'd0, 3'b000, 5'd12), 1, 1, 5'd0, 32'd123);
        chk("rd0_no_pending", {31'd0, instr_ready}, 32'd1);
        tick();
        chk("x0_reads_zero", op1, 32'd0);

        drive(1, i_ins(12'h800, 5'd1, 3'b111, 5'd10), 1, 0, 5'd0, 32'd0);
        tick();
        chk("andi_signext", op2, 32'hFFFF_F800);

        drive(1, i_ins(12'h001, 5'd0, 3'b000, 5'd9), 1, 0, 5'd0, 32'd0);
        chk("waw_stall", {31'd0, instr_ready}, 32'd0);
        drive(1, i_ins(12'h001, 5'd0, 3'b000, 5'd9), 1, 1, 5'd9, 32'd7);
        chk("waw_wb_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        drive(1, i_ins(12'h000, 5'd9, 3'b000, 5'd11), 1, 0, 5'd0, 32'd0);
        chk("set_wins_stall", {31'd0, instr_ready}, 32'd0);
        tick();
        drive(1, i_ins(12'h000, 5'd9, 3'b000, 5'd11), 1, 1, 5'd9, 32'h55);
        tick();
        chk("set_wins_bypass", op1, 32'h55);

        drive(1, r_ins(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd5), 1, 0, 5'd0, 32'd0);
        tick();
        drive(0, 32'd0, 0, 0, 5'd0, 32'd0);
        tick();
        chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_flush_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_flush_op1", op1, 32'd0);
        drive(1, i_ins(12'h000, 5'd5, 3'b000, 5'd5), 1, 0, 5'd0, 32'd0);
        chk("rst_clears_pending", {31'd0, instr_ready}, 32'd1);
        tick();
        drive(1, i_ins(12'h000, 5'd1, 3'b000, 5'd16), 1, 0, 5'd0, 32'd0);
        tick();
        chk("rst_clears_x1", op1, 32'd0);

        drive(0, 32'd0, 1, 0, 5'd0, 32'd0);
        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 The block SHALL have no parameters; all datapaths SHALL be 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 instr_valid  input  1  upstream fetch presents an instruction.
REQ-005 instr  input  32  RV32I instruction word.
REQ-006 instr_ready  output  1  stage accepts instr this cycle.
REQ-007 ex_valid  output  1  operand bundle valid for the ALU stage.
REQ-008 ex_ready  input  1  ALU stage consumes the bundle this cycle.
REQ-009 op1  output  32  ALU operand 1 (rs1 value).
REQ-010 op2  output  32  ALU operand 2 (rs2 value or sign-extended imm).
REQ-011 alu_sel  output  2  00 add, 01 sub, 10 or, 11 and.
REQ-012 rd  output  5  destination register of the bundle.
REQ-013 wb_en  input  1  writeback strobe.
REQ-014 wb_rd  input  5  writeback register index.
REQ-015 wb_data  input  32  writeback value.
REQ-016 illegal_instr  output  1  one-cycle pulse on an accepted unsupported instruction.

Function
REQ-017 The block SHALL hold a 32x32 register file; x0 SHALL read 0 and ignore writes.
REQ-018 Decode: opcode 0110011 with funct7/funct3 0000000/000 add, 0100000/000 sub, 0000000/110 or, 0000000/111 and; opcode 0010011 funct3 000 addi, 110 ori, 111 andi; all else illegal.
REQ-019 I-type op2 SHALL be instr[31:20] sign-extended to 32 bits; alu_sel per REQ-011 (addi 00, ori 10, andi 11).
REQ-020 A 32-bit pending scoreboard SHALL mark registers with an issued but not written-back result.
REQ-021 hazard SHALL be 1 when a used source (rs1; rs2 for R-type only) or rd (if nonzero) is pending and not being cleared by wb_en/wb_rd in the same cycle.
REQ-022 instr_ready SHALL equal (!ex_valid || ex_ready) && !hazard, combinationally.
REQ-023 Accept = instr_valid && instr_ready; on accept of a legal instruction, op1/op2/alu_sel/rd SHALL register and ex_valid SHALL be 1 the next cycle (latency 1).
REQ-024 Register reads SHALL bypass: if wb_en && wb_rd == source && source != 0 the same cycle, the operand SHALL be wb_data.
REQ-025 ex_valid SHALL clear after ex_ready && ex_valid with no new legal accept; while ex_valid && !ex_ready, all ex outputs SHALL hold stable.
REQ-026 On legal accept with rd != 0, pending[rd] SHALL set; on wb_en, pending[wb_rd] SHALL clear; set SHALL win on the same index in the same cycle.
REQ-027 Illegal accept SHALL pulse illegal_instr for one cycle, SHALL NOT assert ex_valid, and SHALL NOT touch the scoreboard.
REQ-028 rd = 0 instructions SHALL issue normally with no scoreboard effect.
REQ-029 wb_en SHALL write the register file on every cycle regardless of handshake state.

Reset
REQ-030 With rst high at a clock edge: ex_valid, illegal_instr, op1, op2, alu_sel, rd, all pending bits and all registers SHALL be 0 next cycle; in-flight bundles SHALL be discarded.
REQ-031 During rst, instr_ready SHALL be 0, and wb_en SHALL be ignored.

Verification
REQ-032 Reset, wb x1=5, x2=3; issue sub x3,x1,x2 with ex_ready=1 -> next cycle ex_valid=1, op1=5, op2=3, alu_sel=01, rd=3.
REQ-033 addi x4,x0,-1 -> op1=0, op2=0xFFFFFFFF, alu_sel=00.
REQ-034 Issue add x5,x1,x2 then or x6,x5,x1 -> instr_ready=0 until wb x5; with wb_en x5=0xA5 in the stall cycle, or issues next cycle with op1=0xA5.
REQ-035 ex_ready=0 for 3 cycles with ex_valid=1 -> outputs stable, instr_ready=0; ex_ready=1 -> accept resumes same cycle.
REQ-036 Opcode 0000011 (load) -> illegal_instr pulses once, ex_valid stays 0, pending unchanged.
REQ-037 rst asserted while ex_valid=1 and pending[5]=1 -> next cycle ex_valid=0, pending=0, x1 reads 0.
